// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port between CPU instruction and data
// interfaces, with in-order source tracking for up to MAX_OUTSTANDING transactions.
// Optional stall counters are enabled by defining RAM_ARB_PERF_EN.
module ram_rr_arbiter #(
  parameter int unsigned SOC_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [SOC_ADDR_WIDTH-1:0] cpu_instr_addr_i,
  input  logic                      cpu_instr_req_i,
  output logic                      cpu_instr_gnt_o,
  output logic                      cpu_instr_rvalid_o,
  output logic [31:0]               cpu_instr_rdata_o,
  input  logic [SOC_ADDR_WIDTH-1:0] cpu_data_addr_i,
  input  logic                      cpu_data_req_i,
  output logic                      cpu_data_gnt_o,
  output logic                      cpu_data_rvalid_o,
  output logic [31:0]               cpu_data_rdata_o,
  input  logic [3:0]                cpu_data_be_i,
  input  logic                      cpu_data_we_i,
  input  logic [31:0]               cpu_data_wdata_i,
  output logic                      soc_req_o,
  input  logic                      soc_gnt_i,
  output logic [SOC_ADDR_WIDTH-1:0] soc_addr_o,
  output logic [3:0]                soc_be_o,
  output logic                      soc_we_o,
  output logic [31:0]               soc_wdata_o,
  input  logic                      soc_rvalid_i,
  input  logic [31:0]               soc_rdata_i
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]               instr_stall_cnt_o,
  output logic [31:0]               data_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_lock;
  logic                       r_lock_src;
  logic                       r_last_src;

  logic w_sel_vld;
  logic w_sel;
  logic w_sel_req;
  logic w_full;
  logic w_soc_req;
  logic w_hs;
  logic w_pop;
  logic w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Source selection: a locked (presented, ungranted) request wins, else round-robin on ties
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = SRC_INSTR;
    if (r_lock) begin
      w_sel_vld = 1'b1;
      w_sel     = r_lock_src;
    end else if (cpu_instr_req_i && cpu_data_req_i) begin
      w_sel_vld = 1'b1;
      w_sel     = ~r_last_src;
    end else if (cpu_data_req_i) begin
      w_sel_vld = 1'b1;
      w_sel     = SRC_DATA;
    end else if (cpu_instr_req_i) begin
      w_sel_vld = 1'b1;
      w_sel     = SRC_INSTR;
    end
  end

  assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_sel_req = w_sel_vld & ((w_sel == SRC_DATA) ? cpu_data_req_i : cpu_instr_req_i);
  assign w_soc_req = rst_ni & w_sel_req & ~w_full;
  assign w_hs      = w_soc_req & soc_gnt_i;
  assign w_pop     = rst_ni & soc_rvalid_i & (r_count != '0);
  assign w_head    = r_fifo[r_rd_ptr];

  // Shared-port mux, grant and response routing; everything is forced low during reset
  always_comb begin
    soc_req_o          = w_soc_req;
    soc_addr_o         = '0;
    soc_be_o           = '0;
    soc_we_o           = 1'b0;
    soc_wdata_o        = '0;
    cpu_instr_gnt_o    = w_hs & (w_sel == SRC_INSTR);
    cpu_data_gnt_o     = w_hs & (w_sel == SRC_DATA);
    cpu_instr_rvalid_o = w_pop & (w_head == SRC_INSTR);
    cpu_data_rvalid_o  = w_pop & (w_head == SRC_DATA);
    cpu_instr_rdata_o  = '0;
    cpu_data_rdata_o   = '0;
    if (rst_ni && w_sel_vld) begin
      if (w_sel == SRC_DATA) begin
        soc_addr_o  = cpu_data_addr_i;
        soc_be_o    = cpu_data_be_i;
        soc_we_o    = cpu_data_we_i;
        soc_wdata_o = cpu_data_wdata_i;
      end else begin
        soc_addr_o  = cpu_instr_addr_i;
      end
    end
    if (cpu_instr_rvalid_o) cpu_instr_rdata_o = soc_rdata_i;
    if (cpu_data_rvalid_o)  cpu_data_rdata_o  = soc_rdata_i;
  end

  // Source-ID FIFO, lock and round-robin history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INSTR;
      r_last_src <= SRC_INSTR;
    end else begin
      if (w_hs) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
        r_last_src       <= w_sel;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Lock holds exactly while a presented request waits for its grant
      r_lock <= w_soc_req & ~soc_gnt_i;
      if (w_soc_req && !soc_gnt_i) r_lock_src <= w_sel;
    end
  end

`ifdef RAM_ARB_PERF_EN
  logic [31:0] r_instr_stall_cnt;
  logic [31:0] r_data_stall_cnt;

  // Saturating stall counters: request high without a grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instr_stall_cnt <= '0;
      r_data_stall_cnt  <= '0;
    end else begin
      if (cpu_instr_req_i && !cpu_instr_gnt_o && (r_instr_stall_cnt != 32'hFFFF_FFFF))
        r_instr_stall_cnt <= r_instr_stall_cnt + 32'd1;
      if (cpu_data_req_i && !cpu_data_gnt_o && (r_data_stall_cnt != 32'hFFFF_FFFF))
        r_data_stall_cnt <= r_data_stall_cnt + 32'd1;
    end
  end

  assign instr_stall_cnt_o = r_instr_stall_cnt;
  assign data_stall_cnt_o  = r_data_stall_cnt;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed testbench for ram_rr_arbiter (default MAX_OUTSTANDING = 2).
// Define RAM_ARB_PERF_EN to also exercise the stall counters.
module tb_ram_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_req;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [31:0] d_addr;
  logic        d_req;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [3:0]  d_be;
  logic        d_we;
  logic [31:0] d_wdata;
  logic        s_req;
  logic        s_gnt;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic        s_we;
  logic [31:0] s_wdata;
  logic        s_rvalid;
  logic [31:0] s_rdata;
`ifdef RAM_ARB_PERF_EN
  logic [31:0] i_stall;
  logic [31:0] d_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  ram_rr_arbiter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cpu_instr_addr_i   (i_addr),
    .cpu_instr_req_i    (i_req),
    .cpu_instr_gnt_o    (i_gnt),
    .cpu_instr_rvalid_o (i_rvalid),
    .cpu_instr_rdata_o  (i_rdata),
    .cpu_data_addr_i    (d_addr),
    .cpu_data_req_i     (d_req),
    .cpu_data_gnt_o     (d_gnt),
    .cpu_data_rvalid_o  (d_rvalid),
    .cpu_data_rdata_o   (d_rdata),
    .cpu_data_be_i      (d_be),
    .cpu_data_we_i      (d_we),
    .cpu_data_wdata_i   (d_wdata),
    .soc_req_o          (s_req),
    .soc_gnt_i          (s_gnt),
    .soc_addr_o         (s_addr),
    .soc_be_o           (s_be),
    .soc_we_o           (s_we),
    .soc_wdata_o        (s_wdata),
    .soc_rvalid_i       (s_rvalid),
    .soc_rdata_i        (s_rdata)
`ifdef RAM_ARB_PERF_EN
    ,
    .instr_stall_cnt_o  (i_stall),
    .data_stall_cnt_o   (d_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, settle, then let checks run
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] be, input logic we,
                       input logic [31:0] wd, input logic g, input logic rv,
                       input logic [31:0] rd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
    d_be = be; d_we = we; d_wdata = wd;
    s_gnt = g; s_rvalid = rv; s_rdata = rd;
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic req, input logic ig, input logic dg,
                         input logic [31:0] addr);
    chk({tag, ".req"},  32'(s_req), 32'(req));
    chk({tag, ".igr"},  32'(i_gnt), 32'(ig));
    chk({tag, ".dgr"},  32'(d_gnt), 32'(dg));
    chk({tag, ".addr"}, s_addr, addr);
  endtask

  task automatic chk_rsp(input string tag, input logic iv, input logic [31:0] id,
                         input logic dv, input logic [31:0] dd);
    chk({tag, ".irv"}, 32'(i_rvalid), 32'(iv));
    chk({tag, ".ird"}, i_rdata, id);
    chk({tag, ".drv"}, 32'(d_rvalid), 32'(dv));
    chk({tag, ".drd"}, d_rdata, dd);
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_req = 0; d_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = 0;
    d_be = 0; d_we = 0; d_wdata = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    i_req = 1; i_addr = 32'h2000; d_req = 1; d_addr = 32'h100;
    d_be = 4'hF; d_we = 1; d_wdata = 32'h1234_5678;
    s_gnt = 1; s_rvalid = 1; s_rdata = 32'h9999_9999;
    #1;
    chk_gnt("rst", 0, 0, 0, 32'h0);
    chk("rst.be", 32'(s_be), 32'h0);
    chk("rst.wd", s_wdata, 32'h0);
    chk_rsp("rst", 0, 32'h0, 0, 32'h0);
    release_reset();

    // Tie from reset: data first, then alternate; rvalids keep one outstanding
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("tie0", 1, 0, 1, 32'h100);
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 1, 32'h1111_1111);
    chk_gnt("tie1", 1, 1, 0, 32'h2000);
    chk_rsp("tie1", 0, 32'h0, 1, 32'h1111_1111);
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 1, 32'h2222_2222);
    chk_gnt("tie2", 1, 0, 1, 32'h100);
    chk_rsp("tie2", 1, 32'h2222_2222, 0, 32'h0);
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 1, 32'h3333_3333);
    chk_gnt("tie3", 1, 1, 0, 32'h2000);
    chk_rsp("tie3", 0, 32'h0, 1, 32'h3333_3333);
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 1, 32'h4444_4444);
    chk_gnt("tie4", 0, 0, 0, 32'h0);
    chk_rsp("tie4", 1, 32'h4444_4444, 0, 32'h0);

    // Lock: make data the last winner, then hold an ungranted data request against instr
    drive(0, 32'h2000, 1, 32'h80, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("lk0", 1, 0, 1, 32'h80);
    drive(0, 32'h2000, 1, 32'h40, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    chk_gnt("lk1", 1, 0, 0, 32'h40);
    drive(1, 32'h2000, 1, 32'h40, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    chk_gnt("lk2", 1, 0, 0, 32'h40);
    drive(1, 32'h2000, 1, 32'h40, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    chk_gnt("lk3", 1, 0, 0, 32'h40);
    drive(1, 32'h2000, 1, 32'h40, 4'h0, 0, 32'h0, 1, 1, 32'h5555_5555);
    chk_gnt("lk4", 1, 0, 1, 32'h40);
    chk_rsp("lk4", 0, 32'h0, 1, 32'h5555_5555);
    drive(1, 32'h2000, 0, 32'h40, 4'h0, 0, 32'h0, 1, 1, 32'h6666_6666);
    chk_gnt("lk5", 1, 1, 0, 32'h2000);
    chk_rsp("lk5", 0, 32'h0, 1, 32'h6666_6666);
    drive(0, 32'h2000, 0, 32'h40, 4'h0, 0, 32'h0, 0, 1, 32'h7777_7777);
    chk_rsp("lk6", 1, 32'h7777_7777, 0, 32'h0);

    // Full: two instr grants, third is stalled even with a same-cycle pop
    drive(1, 32'h3000, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("fu1", 1, 1, 0, 32'h3000);
    drive(1, 32'h3004, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("fu2", 1, 1, 0, 32'h3004);
    drive(1, 32'h3008, 0, 32'h0, 4'h0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
    chk_gnt("fu3", 0, 0, 0, 32'h3008);
    chk_rsp("fu3", 1, 32'hDEAD_BEEF, 0, 32'h0);
    drive(1, 32'h3008, 0, 32'h0, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("fu4", 1, 1, 0, 32'h3008);
    drive(0, 32'h3008, 0, 32'h0, 4'h0, 0, 32'h0, 0, 1, 32'h0000_0001);
    chk_rsp("fu5", 1, 32'h0000_0001, 0, 32'h0);
    drive(0, 32'h3008, 0, 32'h0, 4'h0, 0, 32'h0, 0, 1, 32'h0000_0002);
    chk_rsp("fu6", 1, 32'h0000_0002, 0, 32'h0);

    // Routing: data write then instr fetch, responses return in order
    drive(0, 32'h2000, 1, 32'h100, 4'hF, 1, 32'hA5A5_A5A5, 1, 0, 32'h0);
    chk_gnt("rt0", 1, 0, 1, 32'h100);
    chk("rt0.be", 32'(s_be), 32'hF);
    chk("rt0.we", 32'(s_we), 32'h1);
    chk("rt0.wd", s_wdata, 32'hA5A5_A5A5);
    drive(1, 32'h2000, 0, 32'h100, 4'hF, 1, 32'hA5A5_A5A5, 1, 0, 32'h0);
    chk_gnt("rt1", 1, 1, 0, 32'h2000);
    chk("rt1.be", 32'(s_be), 32'h0);
    chk("rt1.we", 32'(s_we), 32'h0);
    chk("rt1.wd", s_wdata, 32'h0);
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 1, 32'hCAFE_0001);
    chk_rsp("rt2", 0, 32'h0, 1, 32'hCAFE_0001);
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 1, 32'hCAFE_0002);
    chk_rsp("rt3", 1, 32'hCAFE_0002, 0, 32'h0);

    // Spurious rvalid on empty FIFO, then two grants prove the count stayed at zero
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 1, 32'h0000_0BAD);
    chk_rsp("sp0", 0, 32'h0, 0, 32'h0);
    drive(1, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("sp1", 1, 1, 0, 32'h2000);
    drive(0, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("sp2", 1, 0, 1, 32'h100);

    // Reset with two outstanding and data as last winner
    @(negedge clk);
    rst_n = 0;
    i_req = 1;
    #1;
    chk_gnt("mrst", 0, 0, 0, 32'h0);
    release_reset();
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 1, 32'h0000_0BAD);
    chk_rsp("pr0", 0, 32'h0, 0, 32'h0);
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("pr1", 1, 0, 1, 32'h100);
    drive(1, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("pr2", 1, 1, 0, 32'h2000);
    drive(0, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 1, 0, 32'h0);
    chk_gnt("pr3", 0, 0, 0, 32'h100);

`ifdef RAM_ARB_PERF_EN
    // Stall counters: five cycles of ungranted data request from a fresh reset
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("pf.rst", d_stall, 32'h0);
    release_reset();
    for (int k = 0; k < 5; k++)
      drive(0, 32'h2000, 1, 32'h100, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 32'h2000, 0, 32'h100, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    chk("pf.data", d_stall, 32'd5);
    chk("pf.instr", i_stall, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
